// File: rtl/sipo_pkg.sv
// Shared definitions for the serial-in / parallel-out shift register:
// FSM state encoding and the default word width.
package sipo_pkg;

    localparam int unsigned SIPO_DEFAULT_WIDTH = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } sipo_state_e;

endpackage

// File: rtl/sipo_bit_counter.sv
// Counts serial bits of the word being assembled; wraps to 0 on the
// WIDTH-th increment.
// Ports:
//   clk   - clock
//   rst   - synchronous active-high reset
//   clear - synchronous clear (frame abort)
//   inc   - one more bit accepted this cycle
//   count - bits collected so far (registered)
//   done  - registered flag: the next inc completes the word
module sipo_bit_counter
    import sipo_pkg::*;
#(
    parameter int unsigned WIDTH = SIPO_DEFAULT_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       inc,
    output logic [$clog2(WIDTH+1)-1:0] count,
    output logic                       done
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    logic [CNT_W-1:0] count_q;
    logic             done_q;

    // done_q is precomputed so the word-complete decision never depends on
    // an adder output in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count_q <= '0;
            done_q  <= 1'b0;
        end else if (inc) begin
            if (done_q) begin
                count_q <= '0;
                done_q  <= 1'b0;
            end else begin
                count_q <= count_q + CNT_W'(1);
                done_q  <= (count_q == CNT_W'(WIDTH - 2));
            end
        end
    end

    assign count = count_q;
    assign done  = done_q;

endmodule

// File: rtl/sipo_shift_reg.sv
// Serial-in / parallel-out shift register with a one-word output buffer
// and valid/ready handshake.
// Ports:
//   clk       - clock
//   rst       - synchronous active-high reset
//   enb       - bit strobe; d is sampled when high
//   d         - serial data bit
//   clr       - synchronous frame abort (drops the partial word)
//   out_ready - consumer accepts q when out_valid is high
//   q         - assembled parallel word
//   out_valid - q holds an unconsumed word
//   busy      - partial word in progress
//   bit_cnt   - bits collected in the current partial word
//   overrun   - sticky: a completed word was dropped (cleared by rst only)
module sipo_shift_reg
    import sipo_pkg::*;
#(
    parameter int unsigned WIDTH     = SIPO_DEFAULT_WIDTH,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enb,
    input  logic                       d,
    input  logic                       clr,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           q,
    output logic                       out_valid,
    output logic                       busy,
    output logic [$clog2(WIDTH+1)-1:0] bit_cnt,
    output logic                       overrun
);

    // Width sanity check at elaboration.
    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("sipo_shift_reg: WIDTH must be in 2..32");
    end

    sipo_state_e      state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;
    logic             busy_q;
    logic [WIDTH-1:0] shifted;
    logic             complete;
    logic             consume;
    logic             cnt_done;

    assign consume = valid_q & out_ready;

    // Bit counter; clr takes priority over a simultaneous strobe.
    sipo_bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clk   (clk),
        .rst   (rst),
        .clear (clr),
        .inc   (enb & ~clr),
        .count (bit_cnt),
        .done  (cnt_done)
    );

    // Next-state, shift and output-buffer logic.
    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        q_d       = q_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        complete  = 1'b0;

        if (MSB_FIRST) begin
            shifted = {sr_q[WIDTH-2:0], d};
        end else begin
            shifted = {d, sr_q[WIDTH-1:1]};
        end

        if (consume) begin
            valid_d = 1'b0;
        end

        if (clr) begin
            state_d = ST_IDLE;
            sr_d    = '0;
        end else if (enb) begin
            case (state_q)
                ST_IDLE: begin
                    sr_d    = shifted;
                    state_d = ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (cnt_done) begin
                        complete = 1'b1;
                        sr_d     = '0;
                        state_d  = ST_IDLE;
                    end else begin
                        sr_d = shifted;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // The buffer can take the new word if empty or being drained now;
        // otherwise the new word is lost.
        if (complete) begin
            if (!valid_q || consume) begin
                q_d     = shifted;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            sr_q      <= '0;
            q_q       <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            q_q       <= q_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            busy_q    <= (state_d == ST_SHIFT);
        end
    end

    assign q         = q_q;
    assign out_valid = valid_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_sipo_shift_reg.sv
// Self-checking bench for sipo_shift_reg: one MSB-first and one LSB-first
// instance share the stimulus; expected words go through a scoreboard.
module tb_sipo_shift_reg;

    localparam int unsigned W  = 8;
    localparam int unsigned CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          rst, enb, d, clr, out_ready;
    logic [W-1:0]  q_m, q_l;
    logic          vld_m, vld_l, busy_m, busy_l, ovr_m, ovr_l;
    logic [CW-1:0] cnt_m, cnt_l;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [7:0] bits;
        logic [7:0] exp_m;
        logic [7:0] exp_l;
    } vec_t;

    typedef struct packed {
        logic [7:0] m;
        logic [7:0] l;
    } exp_t;

    vec_t vecs[6];
    exp_t sb[$];

    always #5 clk = ~clk;

    sipo_shift_reg #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .enb(enb), .d(d), .clr(clr), .out_ready(out_ready),
        .q(q_m), .out_valid(vld_m), .busy(busy_m), .bit_cnt(cnt_m), .overrun(ovr_m)
    );

    sipo_shift_reg #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .enb(enb), .d(d), .clr(clr), .out_ready(out_ready),
        .q(q_l), .out_valid(vld_l), .busy(busy_l), .bit_cnt(cnt_l), .overrun(ovr_l)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] bitrev(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        enb = 1'b1;
        d   = b;
        step();
        enb = 1'b0;
        d   = 1'b0;
    endtask

    // First bit sent is b[7]; ready_last raises out_ready in the final bit cycle.
    task automatic send_word(input logic [7:0] b, input logic [7:0] em, input logic [7:0] el,
                             input bit push, input bit ready_last);
        exp_t e;
        if (push) begin
            e.m = em;
            e.l = el;
            sb.push_back(e);
        end
        for (int i = 7; i >= 0; i--) begin
            if (i == 0 && ready_last) out_ready = 1'b1;
            send_bit(b[i]);
        end
        if (ready_last) out_ready = 1'b0;
    endtask

    task automatic check_word(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: scoreboard empty, got q=0x%0h", name, q_m);
        end else begin
            e = sb.pop_front();
            check({name, "_valid"}, 32'(vld_m), 32'd1);
            check({name, "_valid_lsb"}, 32'(vld_l), 32'd1);
            check({name, "_q_msb"}, 32'(q_m), 32'(e.m));
            check({name, "_q_lsb"}, 32'(q_l), 32'(e.l));
        end
    endtask

    task automatic consume(input string name);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({name, "_consumed"}, 32'(vld_m), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        enb = 1'b0;
        d = 1'b0;
        clr = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;

        vecs[0] = '{bits: 8'hB2, exp_m: 8'hB2, exp_l: 8'h4D};
        vecs[1] = '{bits: 8'h0F, exp_m: 8'h0F, exp_l: 8'hF0};
        vecs[2] = '{bits: 8'h3C, exp_m: 8'h3C, exp_l: 8'h3C};
        vecs[3] = '{bits: 8'hA5, exp_m: 8'hA5, exp_l: 8'hA5};
        vecs[4] = '{bits: 8'h01, exp_m: 8'h01, exp_l: 8'h80};
        vecs[5] = '{bits: 8'h96, exp_m: 8'h96, exp_l: 8'h69};

        // Reset state.
        do_reset();
        check("rst_q", 32'(q_m), 32'd0);
        check("rst_q_lsb", 32'(q_l), 32'd0);
        check("rst_valid", 32'(vld_m), 32'd0);
        check("rst_busy", 32'(busy_m), 32'd0);
        check("rst_cnt", 32'(cnt_m), 32'd0);
        check("rst_overrun", 32'(ovr_m), 32'd0);
        check("rst_lsb_status", 32'({vld_l, busy_l, cnt_l, ovr_l}), 32'd0);

        // Table of back-to-back words, each drained before the next.
        for (int i = 0; i < 6; i++) begin
            send_word(vecs[i].bits, vecs[i].exp_m, vecs[i].exp_l, 1'b1, 1'b0);
            check_word($sformatf("vec%0d", i));
            check($sformatf("vec%0d_busy", i), 32'(busy_m), 32'd0);
            check($sformatf("vec%0d_cnt", i), 32'(cnt_m), 32'd0);
            consume($sformatf("vec%0d", i));
        end

        // Partial word holds through idle strobes (no timeout).
        b = 8'hC5;
        sb.push_back('{m: b, l: bitrev(b)});
        for (int i = 7; i >= 5; i--) send_bit(b[i]);
        check("hold_cnt3", 32'(cnt_m), 32'd3);
        check("hold_busy3", 32'(busy_m), 32'd1);
        repeat (4) step();
        check("hold_cnt_after_gap", 32'(cnt_m), 32'd3);
        check("hold_busy_after_gap", 32'(busy_m), 32'd1);
        for (int i = 4; i >= 1; i--) send_bit(b[i]);
        check("hold_cnt7", 32'(cnt_m), 32'd7);
        check("hold_valid_before_last", 32'(vld_m), 32'd0);
        send_bit(b[0]);
        check_word("hold");
        consume("hold");

        // Completion while the buffer is full drops the new word.
        do_reset();
        send_word(8'hB2, 8'hB2, 8'h4D, 1'b1, 1'b0);
        check_word("ovr_first");
        send_word(8'h0F, 8'h00, 8'h00, 1'b0, 1'b0);
        check("ovr_q_kept", 32'(q_m), 32'hB2);
        check("ovr_q_kept_lsb", 32'(q_l), 32'h4D);
        check("ovr_valid", 32'(vld_m), 32'd1);
        check("ovr_flag", 32'(ovr_m), 32'd1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("ovr_sticky_clr", 32'(ovr_m), 32'd1);
        check("ovr_clr_keeps_q", 32'(q_m), 32'hB2);
        consume("ovr");
        check("ovr_sticky_consume", 32'(ovr_m), 32'd1);
        do_reset();
        check("ovr_cleared_by_rst", 32'(ovr_m), 32'd0);

        // Consume and complete in the same cycle.
        send_word(8'hB2, 8'hB2, 8'h4D, 1'b1, 1'b0);
        check_word("same_first");
        send_word(8'h0F, 8'h0F, 8'hF0, 1'b1, 1'b1);
        check_word("same_second");
        check("same_overrun", 32'(ovr_m), 32'd0);
        consume("same");

        // Frame abort mid-word, with enb asserted alongside clr.
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        check("clr_cnt5", 32'(cnt_m), 32'd5);
        clr = 1'b1;
        send_bit(1'b1);
        clr = 1'b0;
        check("clr_cnt0", 32'(cnt_m), 32'd0);
        check("clr_busy0", 32'(busy_m), 32'd0);
        check("clr_valid0", 32'(vld_m), 32'd0);
        send_word(8'h3C, 8'h3C, 8'h3C, 1'b1, 1'b0);
        check_word("clr_word");
        check("clr_word_cnt", 32'(cnt_m), 32'd0);
        consume("clr");

        // Reset mid-word (rst beats enb), then gapped strobes.
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        rst = 1'b1;
        send_bit(1'b1);
        rst = 1'b0;
        check("rstmid_q", 32'(q_m), 32'd0);
        check("rstmid_valid", 32'(vld_m), 32'd0);
        check("rstmid_busy", 32'(busy_m), 32'd0);
        check("rstmid_cnt", 32'(cnt_m), 32'd0);
        check("rstmid_overrun", 32'(ovr_m), 32'd0);
        b = 8'h96;
        sb.push_back('{m: b, l: bitrev(b)});
        for (int i = 7; i >= 0; i--) begin
            send_bit(b[i]);
            if (i != 0) begin
                check($sformatf("gap_cnt_bit%0d", 8 - i), 32'(cnt_m), 32'(8 - i));
                check($sformatf("gap_busy_a%0d", i), 32'(busy_m), 32'd1);
                step();
                check($sformatf("gap_busy_b%0d", i), 32'(busy_m), 32'd1);
                step();
                check($sformatf("gap_busy_c%0d", i), 32'(busy_m), 32'd1);
            end
        end
        check_word("gap_word");
        check("gap_busy_done", 32'(busy_m), 32'd0);
        consume("gap");

        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
